// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures a slow, asynchronous clock (clockIn) against the fast board clock:
// reports cmosClock cycles per clockIn period and per high phase, each with a
// one-cycle valid strobe, and flags a stalled input after TIMEOUT cycles
// without a rising edge.
// Optional feature: define CLKMETER_AVG_EN to add avgOut/avgValid, the
// truncated mean of every four accepted periods.
module clock_period_meter #(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             cmosClock,
  input  logic             reset,
  input  logic             clockIn,
  input  logic             measureEn,
  output logic [WIDTH-1:0] periodOut,
  output logic [WIDTH-1:0] highOut,
  output logic             periodValid,
  output logic             highValid,
  output logic             stalled
`ifdef CLKMETER_AVG_EN
  ,
  output logic [WIDTH-1:0] avgOut,
  output logic             avgValid
`endif
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic                   prev_in;
  logic                   rise;
  logic                   fall;
  logic [WIDTH-1:0]       cnt;
  logic                   armed;
  logic                   take_period;
  logic                   take_high;
  logic                   time_out;

  // Bring clockIn into the cmosClock domain and keep one cycle of history for edge detection
  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_in <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], clockIn};
      prev_in <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_in;
  assign fall    = ~sync_in & prev_in;

  // A measurement is only trustworthy once a rise has anchored the counter
  assign take_period = measureEn & rise & armed;
  assign take_high   = measureEn & fall & armed;
  // A rise arriving in the timeout cycle wins, so the timeout is gated by ~rise
  assign time_out    = measureEn & ~rise & (cnt == TIMEOUT_CNT);

  // Cycle counter, arming, stall flag and registered results with their strobes
  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      armed       <= 1'b0;
      stalled     <= 1'b0;
      periodOut   <= '0;
      highOut     <= '0;
      periodValid <= 1'b0;
      highValid   <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      highValid   <= 1'b0;
      if (!measureEn) begin
        cnt     <= '0;
        armed   <= 1'b0;
        stalled <= 1'b0;
      end else if (rise) begin
        cnt     <= WIDTH'(1);
        armed   <= 1'b1;
        stalled <= 1'b0;
        if (take_period) begin
          periodOut   <= cnt;
          periodValid <= 1'b1;
        end
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + WIDTH'(1);
        end
        if (take_high) begin
          highOut   <= cnt;
          highValid <= 1'b1;
        end
        if (time_out) begin
          stalled <= 1'b1;
          armed   <= 1'b0;
        end
      end
    end
  end

`ifdef CLKMETER_AVG_EN
  logic [WIDTH+1:0] avg_sum;
  logic [WIDTH+1:0] avg_total;
  logic [1:0]       avg_num;

  assign avg_total = avg_sum + {2'b00, cnt};

  // Accumulate accepted periods; every fourth one publishes the truncated mean and restarts
  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      avg_sum  <= '0;
      avg_num  <= 2'd0;
      avgOut   <= '0;
      avgValid <= 1'b0;
    end else begin
      avgValid <= 1'b0;
      if (!measureEn || time_out) begin
        avg_sum <= '0;
        avg_num <= 2'd0;
      end else if (take_period) begin
        if (avg_num == 2'd3) begin
          avgOut   <= avg_total[WIDTH+1:2];
          avgValid <= 1'b1;
          avg_sum  <= '0;
          avg_num  <= 2'd0;
        end else begin
          avg_sum <= avg_total;
          avg_num <= avg_num + 2'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
// Directed scenarios plus randomized clockIn waveforms, checked every cycle
// against a timestamp-based model of the meter. Define CLKMETER_AVG_EN to
// also cover the four-period average outputs.
module tb_clock_period_meter;

  localparam int     WIDTH       = 20;
  localparam int     SYNC_STAGES = 2;
  localparam int     TIMEOUT     = 50;
  localparam longint CNT_MAX     = (longint'(1) << WIDTH) - 1;

  logic             cmosClock;
  logic             reset;
  logic             clockIn;
  logic             measureEn;
  logic [WIDTH-1:0] periodOut;
  logic [WIDTH-1:0] highOut;
  logic             periodValid;
  logic             highValid;
  logic             stalled;
`ifdef CLKMETER_AVG_EN
  logic [WIDTH-1:0] avgOut;
  logic             avgValid;
`endif

  int errors = 0;
  int checks = 0;

  // bookkeeping from the compare process, read by the directed scenarios
  int cyc          = 0;
  int pv_count     = 0;
  int hv_count     = 0;
  int av_count     = 0;
  int last_pv_cyc  = 0;
  int stall_on_cyc = -1;
  bit stalled_prev = 1'b0;

  // model state
  bit     samp[$];
  longint edge_n      = 0;
  longint ref_edge    = 0;
  bit     m_armed     = 1'b0;
  longint exp_period  = 0;
  longint exp_high    = 0;
  bit     exp_pv      = 1'b0;
  bit     exp_hv      = 1'b0;
  bit     exp_stalled = 1'b0;
  longint acc[$];
  longint exp_avg     = 0;
  bit     exp_av      = 1'b0;

  clock_period_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .cmosClock   (cmosClock),
    .reset       (reset),
    .clockIn     (clockIn),
    .measureEn   (measureEn),
    .periodOut   (periodOut),
    .highOut     (highOut),
    .periodValid (periodValid),
    .highValid   (highValid),
    .stalled     (stalled)
`ifdef CLKMETER_AVG_EN
    ,
    .avgOut      (avgOut),
    .avgValid    (avgValid)
`endif
  );

  // 100MHz board clock
  initial begin
    cmosClock = 1'b0;
    forever #5 cmosClock = ~cmosClock;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // hold clockIn/measureEn for a number of sampling edges, returning 3ns after the last one
  task automatic applyStimulus(input logic level, input logic en, input int cycles);
    clockIn   = level;
    measureEn = en;
    repeat (cycles) @(posedge cmosClock);
    #3;
  endtask

  // Model: the meter sees clockIn SYNC_STAGES edges late; counts are edge-timestamp differences
  always @(posedge cmosClock or posedge reset) begin
    longint since;
    longint cnt_val;
    longint sum;
    bit     lvl_now;
    bit     lvl_before;
    bit     is_rise;
    bit     is_fall;
    if (reset) begin
      samp.delete();
      for (int i = 0; i < SYNC_STAGES + 1; i++) samp.push_back(1'b0);
      edge_n      = 0;
      ref_edge    = 0;
      m_armed     = 1'b0;
      exp_period  = 0;
      exp_high    = 0;
      exp_pv      = 1'b0;
      exp_hv      = 1'b0;
      exp_stalled = 1'b0;
      acc.delete();
      exp_avg     = 0;
      exp_av      = 1'b0;
    end else begin
      samp.push_back(clockIn);
      if (samp.size() > SYNC_STAGES + 2) void'(samp.pop_front());
      lvl_now    = samp[samp.size() - 1 - SYNC_STAGES];
      lvl_before = samp[samp.size() - 2 - SYNC_STAGES];
      is_rise    = lvl_now & ~lvl_before;
      is_fall    = ~lvl_now & lvl_before;
      since      = edge_n - ref_edge;
      cnt_val    = (since > CNT_MAX) ? CNT_MAX : since;
      exp_pv = 1'b0;
      exp_hv = 1'b0;
      exp_av = 1'b0;
      if (!measureEn) begin
        ref_edge    = edge_n + 1;
        m_armed     = 1'b0;
        exp_stalled = 1'b0;
        acc.delete();
      end else if (is_rise) begin
        if (m_armed) begin
          exp_period = cnt_val;
          exp_pv     = 1'b1;
          acc.push_back(cnt_val);
          if (acc.size() == 4) begin
            sum = 0;
            foreach (acc[i]) sum += acc[i];
            exp_avg = sum / 4;
            exp_av  = 1'b1;
            acc.delete();
          end
        end
        m_armed     = 1'b1;
        exp_stalled = 1'b0;
        ref_edge    = edge_n;
      end else begin
        if (is_fall && m_armed) begin
          exp_high = cnt_val;
          exp_hv   = 1'b1;
        end
        if (since == TIMEOUT) begin
          exp_stalled = 1'b1;
          m_armed     = 1'b0;
          acc.delete();
        end
      end
      edge_n++;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge cmosClock) begin
    cyc++;
    checkOutput("periodValid", periodValid, exp_pv);
    checkOutput("highValid", highValid, exp_hv);
    checkOutput("stalled", stalled, exp_stalled);
    checkOutput("periodOut", periodOut, exp_period);
    checkOutput("highOut", highOut, exp_high);
    checkOutput("strobe_overlap", periodValid & highValid, 0);
`ifdef CLKMETER_AVG_EN
    checkOutput("avgValid", avgValid, exp_av);
    checkOutput("avgOut", avgOut, exp_avg);
    if (avgValid) av_count++;
`endif
    if (periodValid) begin
      pv_count++;
      last_pv_cyc = cyc;
    end
    if (highValid) hv_count++;
    if (stalled && !stalled_prev) stall_on_cyc = cyc;
    stalled_prev = stalled;
  end

  // Directed scenarios followed by randomized waveforms
  initial begin
    int pv0;
    int hv0;
    int av0;
    int hi;
    int lo;
    bit en;

    reset     = 1'b0;
    clockIn   = 1'b0;
    measureEn = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge cmosClock);
    #3;
    checkOutput("reset_periodOut", periodOut, 0);
    checkOutput("reset_highOut", highOut, 0);
    checkOutput("reset_stalled", stalled, 0);
    reset = 1'b0;

    // 1: toggle every 4 cycles
    $display("[TB] scenario 1: period 8, high 4");
    applyStimulus(1'b0, 1'b1, 4);
    pv0 = pv_count;
    hv0 = hv_count;
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t1_no_pv_on_first_rise", pv_count - pv0, 0);
    checkOutput("t1_first_hv", hv_count - hv0, 1);
    checkOutput("t1_first_high", highOut, 4);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t1_pv_on_second_rise", pv_count - pv0, 1);
    checkOutput("t1_period", periodOut, 8);
    checkOutput("t1_model_period", exp_period, 8);
    checkOutput("t1_model_high", exp_high, 4);
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 4);
      applyStimulus(1'b0, 1'b1, 4);
    end

    // 2: high 3 / low 7
    $display("[TB] scenario 2: period 10, high 3");
    repeat (4) begin
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 7);
    end
    checkOutput("t2_period", periodOut, 10);
    checkOutput("t2_high", highOut, 3);

    // 3: stall after 60 low cycles, then resume at period 8
    $display("[TB] scenario 3: stall and recovery");
    stall_on_cyc = -1;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 60);
    checkOutput("t3_stalled", stalled, 1);
    checkOutput("t3_stall_delay", stall_on_cyc - last_pv_cyc, 50);
    pv0 = pv_count;
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t3_stall_cleared", stalled, 0);
    checkOutput("t3_no_stale_pv", pv_count - pv0, 0);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t3_resume_pv", pv_count - pv0, 1);
    checkOutput("t3_resume_period", periodOut, 8);

    // 3b: a rise landing exactly on the timeout cycle beats the timeout
    $display("[TB] scenario 3b: rise coincides with timeout");
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 47);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("t3b_period_50", periodOut, 50);
    checkOutput("t3b_no_stall", stalled, 0);

    // 4: disable mid-period, then re-enable
    $display("[TB] scenario 4: measureEn low mid-period");
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 2);
    pv0 = pv_count;
    hv0 = hv_count;
    applyStimulus(1'b0, 1'b0, 2);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 4);
      applyStimulus(1'b0, 1'b0, 4);
    end
    checkOutput("t4_no_pv_disabled", pv_count - pv0, 0);
    checkOutput("t4_no_hv_disabled", hv_count - hv0, 0);
    checkOutput("t4_period_held", periodOut, 8);
    checkOutput("t4_high_held", highOut, 3);
    applyStimulus(1'b0, 1'b1, 4);
    pv0 = pv_count;
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t4_rearm_no_pv", pv_count - pv0, 0);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t4_rearm_pv", pv_count - pv0, 1);
    checkOutput("t4_rearm_period", periodOut, 8);

    // 5: asynchronous reset in the middle of a high phase
    $display("[TB] scenario 5: asynchronous reset");
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 2);
    reset = 1'b1;
    #1;
    checkOutput("t5_async_periodOut", periodOut, 0);
    checkOutput("t5_async_highOut", highOut, 0);
    checkOutput("t5_async_periodValid", periodValid, 0);
    checkOutput("t5_async_highValid", highValid, 0);
    checkOutput("t5_async_stalled", stalled, 0);
    applyStimulus(1'b0, 1'b1, 3);
    reset = 1'b0;
    pv0 = pv_count;
    av0 = av_count;
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t5_no_pv_first_rise", pv_count - pv0, 0);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t5_pv_second_rise", pv_count - pv0, 1);
    checkOutput("t5_period", periodOut, 8);

    // 6: periods 8,8,10,10 feed the average
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 7);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 7);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("t6_period_count", pv_count - pv0, 4);
    checkOutput("t6_last_period", periodOut, 10);
`ifdef CLKMETER_AVG_EN
    $display("[TB] scenario 6: four-period average");
    checkOutput("t6_avg_once", av_count - av0, 1);
    checkOutput("t6_avg_value", avgOut, 9);
    checkOutput("t6_model_avg", exp_avg, 9);
`endif

    // randomized waveforms, including occasional disables and long lows near the timeout
    $display("[TB] randomized phase");
    repeat (60) begin
      en = ($urandom_range(0, 9) != 0);
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 14);
      if ($urandom_range(0, 6) == 0) lo = $urandom_range(44, 60);
      applyStimulus(1'b1, en, hi);
      if ($urandom_range(0, 11) == 0) en = ~en;
      applyStimulus(1'b0, en, lo);
    end
    applyStimulus(1'b0, 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
